// File: rtl/balance_pkg.sv
// Shared types and helpers for the pitch-balance sequencer.
// Holds the sequencer state encoding and the soft-start duty clamp.
package balance_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        WAIT_RIDER = 2'd1,
        SOFT       = 2'd2,
        RUN        = 2'd3
    } seq_state_t;

    localparam int DUTY_W   = 12;
    localparam int SS_SHIFT = 3;

    // Clamp pid to +/-(tmr << SS_SHIFT), compared one bit wider than duty
    function automatic logic [DUTY_W-1:0] soft_clamp(
        input logic signed [DUTY_W-1:0] pid,
        input logic        [7:0]        tmr
    );
        logic signed [DUTY_W:0] lim;
        logic signed [DUTY_W:0] val;
        logic signed [DUTY_W:0] res;
        lim = $signed({{(DUTY_W+1-8-SS_SHIFT){1'b0}}, tmr,
                       {SS_SHIFT{1'b0}}});
        val = {pid[DUTY_W-1], pid};
        if (val > lim)
            res = lim;
        else if (val < -lim)
            res = -lim;
        else
            res = val;
        return res[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/dismount_tmr.sv
// Dismount debounce: counts consecutive low-weight cycles while active.
// Expires on the cycle the count is all-ones and low is still present.
module dismount_tmr
    import balance_pkg::*;
#(
    parameter int OFF_CNT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic low,
    output logic expired
);

    logic [OFF_CNT_W-1:0] cnt;

    assign expired = en & low & (&cnt);

    // The state leaves on expiry, so clearing here never loses a count
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en && low && !expired)
            cnt <= cnt + OFF_CNT_W'(1);
        else
            cnt <= '0;
    end

endmodule

// File: rtl/balance_seq.sv
// Pitch-balance loop sequencer: power/rider state machine,
// PID sample gating and soft-start limited motor duty.
module balance_seq
    import balance_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter int          OFF_CNT_W    = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pwr_btn,
    input  logic [11:0]              lft_ld,
    input  logic [11:0]              rght_ld,
    input  logic                     ptch_vld,
    input  logic [7:0]               ss_tmr,
    input  logic signed [DUTY_W-1:0] PID_cntrl,
    output logic                     pwr_up,
    output logic                     rider_off,
    output logic                     pid_vld,
    output logic                     mtr_en,
    output logic signed [DUTY_W-1:0] duty,
    output logic [1:0]               state
);

    localparam logic [12:0] ON_THR  = {1'b0, MIN_RIDER_WT};
    localparam logic [12:0] LOW_THR = {1'b0, MIN_RIDER_WT - WT_HYST};

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [12:0]       wt;
    logic              on;
    logic              low;
    logic              active;
    logic              next_active;
    logic              expired;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;

    assign wt          = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign on          = (wt >= ON_THR);
    assign low         = (wt < LOW_THR);
    assign active      = (state_q == SOFT) || (state_q == RUN);
    assign next_active = (state_d == SOFT) || (state_d == RUN);

    dismount_tmr #(
        .OFF_CNT_W(OFF_CNT_W)
    ) u_dis (
        .clk    (clk),
        .rst    (rst),
        .en     (active),
        .low    (low),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= OFF;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (pwr_btn) begin
            state_d = (state_q == OFF) ? WAIT_RIDER : OFF;
        end else begin
            unique case (state_q)
                OFF: state_d = OFF;
                WAIT_RIDER: if (on) state_d = SOFT;
                SOFT: begin
                    if (expired)
                        state_d = WAIT_RIDER;
                    else if (ss_tmr == 8'hFF)
                        state_d = RUN;
                end
                RUN: if (expired) state_d = WAIT_RIDER;
                default: state_d = OFF;
            endcase
        end
    end

    always_comb begin
        pwr_up    = active;
        rider_off = ~active;
        mtr_en    = active;
        pid_vld   = active & ptch_vld;
        state     = state_q;
    end

    // Zero on the first cycle of SOFT and the first cycle after leaving
    always_comb begin
        duty_d = '0;
        if (active && next_active) begin
            if (state_q == RUN)
                duty_d = PID_cntrl;
            else
                duty_d = soft_clamp(PID_cntrl, ss_tmr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            duty_q <= '0;
        else
            duty_q <= duty_d;
    end

    assign duty = $signed(duty_q);

endmodule

// File: tb/tb_balance_seq.sv
// Directed bench for balance_seq with a 16-cycle dismount debounce.
// Expected values are hand-computed constants.
module tb_balance_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               pwr_btn;
    logic [11:0]        lft_ld;
    logic [11:0]        rght_ld;
    logic               ptch_vld;
    logic [7:0]         ss_tmr;
    logic signed [11:0] PID_cntrl;
    logic               pwr_up;
    logic               rider_off;
    logic               pid_vld;
    logic               mtr_en;
    logic signed [11:0] duty;
    logic [1:0]         state;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    balance_seq #(
        .MIN_RIDER_WT(12'h200),
        .WT_HYST     (12'h040),
        .OFF_CNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwr_btn  (pwr_btn),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .ptch_vld (ptch_vld),
        .ss_tmr   (ss_tmr),
        .PID_cntrl(PID_cntrl),
        .pwr_up   (pwr_up),
        .rider_off(rider_off),
        .pid_vld  (pid_vld),
        .mtr_en   (mtr_en),
        .duty     (duty),
        .state    (state)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pwr_btn = 1'b0; lft_ld = '0; rght_ld = '0;
        ptch_vld = 1'b0; ss_tmr = '0; PID_cntrl = '0;
        tick(2);
        chk("rst_state", 12'(state), 12'h0);
        chk("rst_rider_off", 12'(rider_off), 12'h1);
        chk("rst_pwr_up", 12'(pwr_up), 12'h0);
        chk("rst_mtr_en", 12'(mtr_en), 12'h0);
        chk("rst_duty", duty, 12'h0);

        pwr_btn = 1'b1;
        tick();
        chk("rst_over_btn", 12'(state), 12'h0);
        rst = 1'b0;
        tick();
        pwr_btn = 1'b0;
        chk("wait_state", 12'(state), 12'h1);
        chk("wait_rider_off", 12'(rider_off), 12'h1);
        chk("wait_pwr_up", 12'(pwr_up), 12'h0);

        ptch_vld = 1'b1;
        #1;
        chk("wait_pid_vld", 12'(pid_vld), 12'h0);
        ptch_vld = 1'b0;

        lft_ld = 12'h100; rght_ld = 12'h0FF;
        PID_cntrl = 12'sd600; ss_tmr = 8'd10;
        tick();
        chk("below_on", 12'(state), 12'h1);
        rght_ld = 12'h100;
        tick();
        chk("soft_state", 12'(state), 12'h2);
        chk("soft_pwr_up", 12'(pwr_up), 12'h1);
        chk("soft_mtr_en", 12'(mtr_en), 12'h1);
        chk("soft_rider_off", 12'(rider_off), 12'h0);
        chk("soft_first_duty", duty, 12'h000);
        tick();
        chk("clamp_pos80", duty, 12'h050);
        ss_tmr = 8'd100;
        tick();
        chk("clamp_600", duty, 12'h258);
        PID_cntrl = -12'sd600; ss_tmr = 8'd10;
        tick();
        chk("clamp_neg80", duty, 12'hFB0);
        ss_tmr = 8'd0;
        tick();
        chk("clamp_zero", duty, 12'h000);

        PID_cntrl = 12'sd600; ss_tmr = 8'hFF;
        tick();
        chk("run_state", 12'(state), 12'h3);
        chk("run_duty600", duty, 12'h258);
        PID_cntrl = 12'sh7FF; ss_tmr = 8'd0;
        tick();
        chk("run_unclamped", duty, 12'h7FF);

        ptch_vld = 1'b1;
        #1;
        chk("run_pid_vld", 12'(pid_vld), 12'h1);
        ptch_vld = 1'b0;
        #1;
        chk("run_pid_vld_lo", 12'(pid_vld), 12'h0);

        rght_ld = 12'h0BF;
        tick(15);
        chk("low15_run", 12'(state), 12'h3);
        rght_ld = 12'h0C0;
        tick();
        rght_ld = 12'h0BF;
        tick(15);
        chk("relow15_run", 12'(state), 12'h3);
        tick();
        chk("dismount_state", 12'(state), 12'h1);
        chk("dismount_duty", duty, 12'h000);
        chk("dismount_rider_off", 12'(rider_off), 12'h1);

        rght_ld = 12'h100;
        tick();
        ss_tmr = 8'hFF;
        tick();
        chk("rerun_state", 12'(state), 12'h3);
        rght_ld = 12'h0E0;
        tick(100);
        chk("hyst_run", 12'(state), 12'h3);
        rght_ld = 12'h0BF;
        tick(15);
        chk("hyst_cnt_clear", 12'(state), 12'h3);
        pwr_btn = 1'b1;
        tick();
        pwr_btn = 1'b0;
        chk("btn_over_dismount", 12'(state), 12'h0);

        pwr_btn = 1'b1;
        tick();
        pwr_btn = 1'b0;
        rght_ld = 12'h100;
        tick();
        tick();
        chk("run_again", 12'(state), 12'h3);
        PID_cntrl = 12'sd500;
        tick();
        chk("run_duty500", duty, 12'h1F4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 12'(state), 12'h0);
        chk("mid_rst_duty", duty, 12'h000);
        chk("mid_rst_pwr_up", 12'(pwr_up), 12'h0);
        chk("mid_rst_rider_off", 12'(rider_off), 12'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
